// File: rtl/vending_machine_multi_if.sv
// Handshake/bus bundle for vending_machine_multi: coin, selection, refund and
// restock inputs plus all vend/credit/status outputs.
interface vending_machine_multi_if #(
  parameter int unsigned NUM_ITEMS = 4,
  parameter int unsigned AMT_W     = 7,
  parameter int unsigned SEL_W     = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
);
  logic                 one_rupee;
  logic                 two_rupees;
  logic                 five_rupees;
  logic                 sel_valid;
  logic [SEL_W-1:0]     sel_item;
  logic                 cancel;
  logic                 change_ack;
  logic                 restock;
  logic [SEL_W-1:0]     restock_item;
  logic                 dispense;
  logic [SEL_W-1:0]     dispense_item;
  logic [AMT_W-1:0]     amount;
  logic                 change_valid;
  logic [AMT_W-1:0]     change;
  logic                 coin_reject;
  logic                 sel_error;
  logic [NUM_ITEMS-1:0] sold_out;

  modport master (
    output one_rupee, two_rupees, five_rupees, sel_valid, sel_item, cancel,
           change_ack, restock, restock_item,
    input  dispense, dispense_item, amount, change_valid, change, coin_reject,
           sel_error, sold_out
  );

  modport slave (
    input  one_rupee, two_rupees, five_rupees, sel_valid, sel_item, cancel,
           change_ack, restock, restock_item,
    output dispense, dispense_item, amount, change_valid, change, coin_reject,
           sel_error, sold_out
  );
endinterface

// File: rtl/vending_machine_multi.sv
// Multi-item vending machine: coin credit, priced selection, vend, change hold.
// Define VEND_STOCK_EN to build per-item stock counters with restock support.
module vending_machine_multi #(
  parameter int unsigned                 NUM_ITEMS  = 4,
  parameter int unsigned                 AMT_W      = 7,
  parameter logic [NUM_ITEMS*AMT_W-1:0]  PRICES     = {7'd15, 7'd12, 7'd10, 7'd5},
  parameter int unsigned                 MAX_AMOUNT = 99,
  parameter int unsigned                 STOCK_INIT = 3,
  parameter int unsigned                 STOCK_W    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  vending_machine_multi_if.slave  bus
);
  localparam int unsigned SEL_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;

  typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

  state_t               state_q;
  logic [AMT_W-1:0]     amount_q;
  logic [AMT_W-1:0]     change_q;
  logic                 change_valid_q;
  logic                 dispense_q;
  logic [SEL_W-1:0]     dispense_item_q;
  logic                 coin_reject_q;
  logic                 sel_error_q;
  logic [NUM_ITEMS-1:0] sold_out_q;

  logic [AMT_W-1:0] coin_val_c;
  logic [AMT_W:0]   coin_sum_c;
  logic [AMT_W-1:0] price_c;
  logic             coin_any_c;
  logic             coin_one_hot_c;
  logic             accept_coin_c;
  logic             sel_take_c;
  logic             sel_in_range_c;
  logic             sel_sold_out_c;
  logic             vend_ok_c;
  logic             cancel_take_c;
  logic             taking_c;

  // Decode coins, price lookup and the accept/vend/cancel decisions.
  always_comb begin
    coin_val_c     = '0;
    coin_any_c     = bus.one_rupee | bus.two_rupees | bus.five_rupees;
    coin_one_hot_c = 1'b0;
    price_c        = '0;
    sel_sold_out_c = 1'b0;
    case ({bus.one_rupee, bus.two_rupees, bus.five_rupees})
      3'b100:  begin coin_val_c = AMT_W'(1); coin_one_hot_c = 1'b1; end
      3'b010:  begin coin_val_c = AMT_W'(2); coin_one_hot_c = 1'b1; end
      3'b001:  begin coin_val_c = AMT_W'(5); coin_one_hot_c = 1'b1; end
      default: begin coin_val_c = '0;        coin_one_hot_c = 1'b0; end
    endcase
    coin_sum_c = {1'b0, amount_q} + {1'b0, coin_val_c};
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (bus.sel_item == SEL_W'(i)) begin
        price_c        = PRICES[i*AMT_W +: AMT_W];
        sel_sold_out_c = sold_out_q[i];
      end
    end
    taking_c       = (state_q == IDLE) || (state_q == CREDIT);
    sel_in_range_c = {1'b0, bus.sel_item} < (SEL_W+1)'(NUM_ITEMS);
    accept_coin_c  = taking_c && coin_one_hot_c && !bus.sel_valid && !bus.cancel &&
                     (coin_sum_c <= (AMT_W+1)'(MAX_AMOUNT));
    // Cancel shadows any simultaneous selection, even where cancel itself is ignored.
    sel_take_c     = taking_c && bus.sel_valid && !bus.cancel;
    vend_ok_c      = sel_take_c && sel_in_range_c && !sel_sold_out_c && (amount_q >= price_c);
    cancel_take_c  = (state_q == CREDIT) && bus.cancel;
  end

  // Main FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      amount_q        <= '0;
      change_q        <= '0;
      change_valid_q  <= 1'b0;
      dispense_q      <= 1'b0;
      dispense_item_q <= '0;
      coin_reject_q   <= 1'b0;
      sel_error_q     <= 1'b0;
    end else begin
      dispense_q    <= 1'b0;
      coin_reject_q <= coin_any_c && !accept_coin_c;
      sel_error_q   <= sel_take_c && !vend_ok_c;
      case (state_q)
        IDLE, CREDIT: begin
          if (cancel_take_c) begin
            state_q        <= CHANGE;
            change_q       <= amount_q;
            change_valid_q <= 1'b1;
            amount_q       <= '0;
          end else if (vend_ok_c) begin
            state_q         <= VEND;
            dispense_q      <= 1'b1;
            dispense_item_q <= bus.sel_item;
            amount_q        <= amount_q - price_c;
          end else if (accept_coin_c) begin
            state_q  <= CREDIT;
            amount_q <= coin_sum_c[AMT_W-1:0];
          end
        end
        VEND: begin
          if (amount_q != '0) begin
            state_q        <= CHANGE;
            change_q       <= amount_q;
            change_valid_q <= 1'b1;
            amount_q       <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        CHANGE: begin
          if (bus.change_ack) begin
            state_q        <= IDLE;
            change_q       <= '0;
            change_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef VEND_STOCK_EN
  logic [STOCK_W-1:0] stock_q   [NUM_ITEMS];
  logic [STOCK_W-1:0] stock_nxt [NUM_ITEMS];

  // Restock of an item overrides a same-cycle vend of that item.
  always_comb begin
    for (int i = 0; i < NUM_ITEMS; i++) begin
      stock_nxt[i] = stock_q[i];
      if (bus.restock && (bus.restock_item == SEL_W'(i)))
        stock_nxt[i] = STOCK_W'(STOCK_INIT);
      else if (vend_ok_c && (bus.sel_item == SEL_W'(i)))
        stock_nxt[i] = stock_q[i] - STOCK_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (reset) begin
        stock_q[i]    <= STOCK_W'(STOCK_INIT);
        sold_out_q[i] <= (STOCK_INIT == 0);
      end else begin
        stock_q[i]    <= stock_nxt[i];
        sold_out_q[i] <= (stock_nxt[i] == '0);
      end
    end
  end
`else
  logic unused_restock;
  assign unused_restock = ^{bus.restock, bus.restock_item, STOCK_W'(STOCK_INIT)};

  always_ff @(posedge clk) begin
    sold_out_q <= '0;
  end
`endif

  assign bus.dispense      = dispense_q;
  assign bus.dispense_item = dispense_item_q;
  assign bus.amount        = amount_q;
  assign bus.change_valid  = change_valid_q;
  assign bus.change        = change_q;
  assign bus.coin_reject   = coin_reject_q;
  assign bus.sel_error     = sel_error_q;
  assign bus.sold_out      = sold_out_q;
endmodule

// File: doc/vending_machine_multi.md
VENDING_MACHINE_MULTI -- requirements
Module: vending_machine_multi

Interface
REQ-001 Parameter NUM_ITEMS, default 4: number of selectable items, range 2..16.
REQ-002 Parameter AMT_W, default 7: width of all money quantities.
REQ-003 Parameter PRICES, default {7'd15,7'd12,7'd10,7'd5}: packed NUM_ITEMS*AMT_W vector; item i price is slice i, with item 0 in the LSB slice.
REQ-004 Parameter MAX_AMOUNT, default 99: credit ceiling.
REQ-005 Parameter STOCK_INIT, default 3: per-item stock after reset or restock; STOCK_W, default 4: stock counter width.
REQ-006 Localparam SEL_W = max(1, $clog2(NUM_ITEMS)).
REQ-007 clk  input  1  single clock; all logic on rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 one_rupee / two_rupees / five_rupees  input  1 each  one-cycle coin pulses.
REQ-010 sel_valid  input  1  selection strobe; sel_item  input  SEL_W  item index.
REQ-011 cancel  input  1  refund request pulse.
REQ-012 change_ack  input  1  change-taken acknowledge.
REQ-013 restock  input  1  restock strobe; restock_item  input  SEL_W  item to refill.
REQ-014 dispense  output  1  one-cycle vend pulse; dispense_item  output  SEL_W  vended item.
REQ-015 amount  output  AMT_W  current credit.
REQ-016 change_valid  output  1; change  output  AMT_W  refund value.
REQ-017 coin_reject  output  1; sel_error  output  1  one-cycle error pulses.
REQ-018 sold_out  output  NUM_ITEMS  bit i high when item i stock is 0.

Function
REQ-019 The FSM SHALL have four states: IDLE (amount 0), CREDIT (amount >0), VEND, CHANGE. All outputs SHALL be registered.
REQ-020 In IDLE or CREDIT, exactly one coin pulse SHALL add 1, 2 or 5 to amount at the next edge; the FSM then goes to CREDIT.
REQ-021 A coin SHALL be rejected, with coin_reject=1 for one cycle and amount unchanged, in any of these cases: more than one coin input is high; amount+coin > MAX_AMOUNT; state is VEND or CHANGE; sel_valid or cancel is high in the same cycle.
REQ-022 When sel_valid is high in IDLE or CREDIT, and sel_item < NUM_ITEMS, the item is not sold out, and amount >= price: at the next edge the FSM SHALL enter VEND, set dispense=1, set dispense_item=sel_item, set amount=amount-price, and decrement stock.
REQ-023 A failed selection (index out of range, item sold out, or insufficient credit) SHALL pulse sel_error for one cycle and leave state and amount unchanged.
REQ-024 The edge leaving VEND SHALL clear dispense; if amount >0 the FSM enters CHANGE with change=amount, change_valid=1, amount=0; otherwise it enters IDLE.
REQ-025 cancel in CREDIT SHALL enter CHANGE with change=amount and amount=0, with no dispense; cancel in IDLE, VEND or CHANGE SHALL be ignored.
REQ-026 cancel and sel_valid high in the same cycle: cancel SHALL win and the selection is ignored, with no sel_error.
REQ-027 change_valid SHALL stay high, with change stable, until change_ack is sampled high; the next edge then clears change_valid and change and enters IDLE. change_ack outside CHANGE SHALL be ignored.
REQ-028 Vend latency: dispense is high in cycle N+1 for sel_valid in cycle N; change_valid is first high in cycle N+2.

Reset
REQ-029 reset SHALL, in any state including mid-VEND and mid-CHANGE: set state to IDLE; clear amount, change, change_valid, dispense, dispense_item, coin_reject and sel_error to 0; set every stock counter to STOCK_INIT. Pending credit is discarded.

Configuration
REQ-030 Macro VEND_STOCK_EN defined: per-item stock counters SHALL be built; sold_out reflects stock == 0; restock at any edge sets stock[restock_item] = STOCK_INIT (index out of range is ignored); restock takes priority over a simultaneous decrement of the same item.
REQ-031 Macro VEND_STOCK_EN undefined: no stock counters SHALL be built; sold_out is tied to 0; restock and restock_item are ignored; items never sell out.

Verification (defaults)
REQ-032 reset, five_rupees, then sel_item=1 -> sel_error pulse; amount stays 5; no dispense.
REQ-033 Coins 5,5,2 (amount 12), then sel_item=1 -> dispense=1 and dispense_item=1 at N+1; change_valid=1 and change=2 at N+2, held until change_ack, then IDLE with amount 0.
REQ-034 Coins 2,1, then cancel -> change_valid=1 with change=3; dispense never asserts; amount 0.
REQ-035 one_rupee and two_rupees in the same cycle -> coin_reject, amount unchanged; with amount 95, five_rupees -> coin_reject and amount stays 95.
REQ-036 With VEND_STOCK_EN defined, buy item 0 three times with exact 5 -> sold_out[0]=1; a fourth selection gives sel_error; restock of item 0 -> sold_out[0]=0.
REQ-037 reset asserted during VEND with amount 7 -> next cycle amount 0, dispense 0, change_valid 0, FSM in IDLE.
